plab2_mem_req_responder: RTL

Memory-side responder for the 8/32/32 memory request/response protocol that the pipelined processor issues on its imem and dmem ports. It accepts request messages and applies reads and writes to an internal word-organised array. Responses return in order after a fixed, parameterised latency, through a credit-limited response queue. It serves as the test memory behind either processor port.

---
 rtl/plab2_mem_req_responder_pkg.sv | 69 ++++++
 rtl/plab2_mem_req_responder_if.sv | 25 ++
 rtl/plab2_mem_resp_queue.sv | 69 ++++++
 rtl/plab2_mem_req_responder.sv | 122 ++++++++++++
 4 files changed

// File: rtl/plab2_mem_req_responder_pkg.sv
// plab2_mem_req_responder_pkg
//   Shared 8/32/32 memory message definitions: field layout (as packed
//   structs whose bit order matches the wire format), type constants, and
//   the byte-lane helpers (len/offset decode, read alignment, write merge)
//   intended for reuse by future cache blocks.
package plab2_mem_req_responder_pkg;

    localparam int REQ_W  = 75;
    localparam int RESP_W = 43;

    localparam logic TYPE_READ  = 1'b0;
    localparam logic TYPE_WRITE = 1'b1;

    // [74] type, [73:66] opaque, [65:34] addr, [33:32] len, [31:0] data
    typedef struct packed {
        logic        typ;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } memreq_t;

    // [42] type, [41:34] opaque, [33:32] len, [31:0] data
    typedef struct packed {
        logic        typ;
        logic [7:0]  opaque;
        logic [1:0]  len;
        logic [31:0] data;
    } memresp_t;

    // Byte enables within the word; lanes shifted past byte 3 fall off the
    // 4-bit result, which is exactly the "dropped bytes" rule.
    function automatic logic [3:0] byte_en(input logic [1:0] len, input logic [1:0] off);
        logic [3:0] m;
        case (len)
            2'd0:    m = 4'b1111;
            2'd1:    m = 4'b0001;
            2'd2:    m = 4'b0011;
            default: m = 4'b0111;
        endcase
        return m << off;
    endfunction

    // Shift the selected bytes down to bit 0 and zero-extend.
    function automatic logic [31:0] read_align(input logic [31:0] word, input logic [1:0] len,
                                               input logic [1:0] off);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (len)
            2'd1:    return {24'b0, sh[7:0]};
            2'd2:    return {16'b0, sh[15:0]};
            2'd3:    return {8'b0, sh[23:0]};
            default: return sh;
        endcase
    endfunction

    // Low-aligned write data lands at byte 'off'; only enabled lanes change.
    function automatic logic [31:0] write_merge(input logic [31:0] old, input logic [31:0] wdata,
                                                input logic [3:0] be, input logic [1:0] off);
        logic [31:0] sh;
        logic [31:0] res;
        sh  = wdata << {off, 3'b000};
        res = old;
        for (int i = 0; i < 4; i++)
            if (be[i]) res[8*i +: 8] = sh[8*i +: 8];
        return res;
    endfunction

endpackage

// File: rtl/plab2_mem_req_responder_if.sv
// plab2_mem_req_responder_if
//   Request/response handshake bundle between a processor memory port
//   (master) and the memory responder (slave).
//   memreq_msg/val/rdy   : 75-bit request, master -> slave
//   memresp_msg/val/rdy  : 43-bit response, slave -> master
interface plab2_mem_req_responder_if;

    logic [plab2_mem_req_responder_pkg::REQ_W-1:0]  memreq_msg;
    logic                                           memreq_val;
    logic                                           memreq_rdy;
    logic [plab2_mem_req_responder_pkg::RESP_W-1:0] memresp_msg;
    logic                                           memresp_val;
    logic                                           memresp_rdy;

    modport master (
        output memreq_msg, memreq_val, memresp_rdy,
        input  memreq_rdy, memresp_msg, memresp_val
    );

    modport slave (
        input  memreq_msg, memreq_val, memresp_rdy,
        output memreq_rdy, memresp_msg, memresp_val
    );

endinterface

// File: rtl/plab2_mem_resp_queue.sv
// plab2_mem_resp_queue
//   Circular response FIFO, DEPTH entries (any value >= 2, not only powers
//   of two). Enqueue and dequeue may happen together at any occupancy,
//   including full. The caller guarantees no enqueue when full without a
//   matching dequeue.
//   clk, reset     : clock, async active-low reset
//   enq_val_i/msg_i: enqueue request
//   deq_val_o/msg_o: head valid / head entry (zero when empty)
//   deq_rdy_i      : consumer takes the head this cycle
module plab2_mem_resp_queue
    import plab2_mem_req_responder_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     enq_val_i,
    input  memresp_t enq_msg_i,
    output logic     deq_val_o,
    output memresp_t deq_msg_o,
    input  logic     deq_rdy_i
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    memresp_t        buf_q [DEPTH];
    logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic            deq;

    // Pointers wrap at DEPTH explicitly since DEPTH may not be 2^PW.
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign deq_val_o = (count_q != '0);
    assign deq       = deq_val_o & deq_rdy_i;
    assign deq_msg_o = deq_val_o ? buf_q[head_q] : '0;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (enq_val_i) tail_d = wrap_inc(tail_q);
        if (deq)       head_d = wrap_inc(head_q);
        if (enq_val_i && !deq)      count_d = count_q + CW'(1);
        else if (!enq_val_i && deq) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // When full with a simultaneous dequeue, tail == head: the old head has
    // already been presented this cycle, so overwriting it at the edge is safe.
    always_ff @(posedge clk) begin
        if (enq_val_i) buf_q[tail_q] <= enq_msg_i;
    end

endmodule

// File: rtl/plab2_mem_req_responder.sv
// plab2_mem_req_responder
//   Test memory behind a processor imem/dmem port. Requests access a
//   word array at the accept edge; responses return in order after
//   p_latency cycles through a credit-limited response queue.
//   clk   : clock
//   reset : async active-low reset (control state only; array keeps data)
//   mem   : slave side of the request/response handshake bundle
module plab2_mem_req_responder
    import plab2_mem_req_responder_pkg::*;
#(
    parameter int p_mem_nwords  = 256,
    parameter int p_latency     = 1,
    parameter int p_resp_qdepth = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    plab2_mem_req_responder_if.slave   mem
);

    localparam int IDX_W = $clog2(p_mem_nwords);
    localparam int CNT_W = $clog2(p_resp_qdepth + 1);

    memreq_t          req;
    memresp_t         resp_d;
    memresp_t         enq_msg;
    logic             enq_val;
    logic [IDX_W-1:0] idx;
    logic [1:0]       off;
    logic             req_fire, resp_fire;
    logic             en_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      mem_q [p_mem_nwords];
    logic             unused_addr_hi;

    assign req            = memreq_t'(mem.memreq_msg);
    assign idx            = req.addr[IDX_W+1:2];
    assign off            = req.addr[1:0];
    assign unused_addr_hi = ^req.addr[31:IDX_W+2];

    // en_q holds memreq_rdy low through reset and rises on the first edge
    // after release, keeping memreq_rdy a pure function of flops.
    assign mem.memreq_rdy = en_q && (cnt_q < CNT_W'(p_resp_qdepth));
    assign req_fire       = mem.memreq_val & mem.memreq_rdy;
    assign resp_fire      = mem.memresp_val & mem.memresp_rdy;

    // Credits: accepted requests whose responses are not yet dequeued.
    // This bounds in-flight plus queued entries, so the queue cannot overflow.
    always_comb begin
        cnt_d = cnt_q;
        if (req_fire && !resp_fire)      cnt_d = cnt_q + CNT_W'(1);
        else if (!req_fire && resp_fire) cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            en_q  <= 1'b1;
            cnt_q <= cnt_d;
        end
    end

    // Array: asynchronous read sampled at the accept edge, write committed
    // at the same edge. Not reset.
    always_ff @(posedge clk) begin
        if (req_fire && req.typ == TYPE_WRITE)
            mem_q[idx] <= write_merge(mem_q[idx], req.data, byte_en(req.len, off), off);
    end

    always_comb begin
        resp_d        = '0;
        resp_d.typ    = req.typ;
        resp_d.opaque = req.opaque;
        resp_d.len    = req.len;
        resp_d.data   = (req.typ == TYPE_WRITE) ? 32'h0 : read_align(mem_q[idx], req.len, off);
    end

    // p_latency-1 register stages; with latency 1 the response enqueues at
    // the accept edge itself.
    generate
        if (p_latency == 1) begin : g_nopipe
            assign enq_val = req_fire;
            assign enq_msg = resp_d;
        end else begin : g_pipe
            localparam int STAGES = p_latency - 2;
            logic [STAGES:0] vld_pipe;
            memresp_t        msg_pipe [STAGES+1];

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) vld_pipe <= '0;
                else begin
                    vld_pipe[0] <= req_fire;
                    for (int k = 1; k <= STAGES; k++) vld_pipe[k] <= vld_pipe[k-1];
                end
            end

            always_ff @(posedge clk) begin
                msg_pipe[0] <= resp_d;
                for (int k = 1; k <= STAGES; k++) msg_pipe[k] <= msg_pipe[k-1];
            end

            assign enq_val = vld_pipe[STAGES];
            assign enq_msg = msg_pipe[STAGES];
        end
    endgenerate

    memresp_t deq_msg;

    plab2_mem_resp_queue #(.DEPTH(p_resp_qdepth)) u_resp_queue (
        .clk       (clk),
        .reset     (reset),
        .enq_val_i (enq_val),
        .enq_msg_i (enq_msg),
        .deq_val_o (mem.memresp_val),
        .deq_msg_o (deq_msg),
        .deq_rdy_i (mem.memresp_rdy)
    );

    assign mem.memresp_msg = deq_msg;

endmodule
